bpu_update_queue: RTL and testbench
===================================

# bpu_update_queue

Decoupling queue between the integer writeback pipeline register and the frontend BHT/BTB arrays. It captures each branch-predictor update packet produced by the branch unit, one cycle after execute. It drains the packets in order into the shared BHT/BTB write port whenever the frontend lookup does not own that port. Without it, updates that collide with a fetch-side lookup would be lost.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- DROP_CNT_W, 16, width of saturating drop counter

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- intwb_bjusb_bht_write_enable  input  1  BHT update request
- intwb_bjusb_bht_write_index  input  `BHTBTB_INDEX_WIDTH  BHT set index
- intwb_bjusb_bht_write_counter_select  input  2  counter within set
- intwb_bjusb_bht_write_inc / _dec  input  1 each  counter direction
- intwb_bjusb_bht_valid_in  input  1  valid bit to write
- intwb_bjusb_btb_ce / _we  input  1 each  BTB chip/write enable
- intwb_bjusb_btb_wmask  input  129  BTB bit mask
- intwb_bjusb_btb_write_index  input  9  BTB index
- intwb_bjusb_btb_din  input  129  BTB data
- bpu_port_busy  input  1  frontend lookup owns the BHT/BTB port this cycle
- upd_bht_write_enable, upd_bht_write_index, upd_bht_write_counter_select, upd_bht_write_inc, upd_bht_write_dec, upd_bht_valid_in  output  same widths  BHT write port
- upd_btb_ce, upd_btb_we, upd_btb_wmask, upd_btb_write_index, upd_btb_din  output  same widths  BTB write port
- upd_pending  output  1  queue non-empty
- upd_drop_cnt  output  DROP_CNT_W  saturating count of dropped packets

## Operation
- Enqueue condition `enq = bht_write_enable | (btb_ce & btb_we)`. Store every input field as one entry, with the enables exactly as received.
- Dequeue condition `deq = !empty & !bpu_port_busy`. When deq is high, drive the head entry on the upd_* ports: upd_bht_write_enable = head.bht_we, upd_btb_ce = head.btb_ce, upd_btb_we = head.btb_we. All other upd_* fields carry the head data.
- When deq is low, all upd_* enables (bht_write_enable, btb_ce, btb_we) are 0. Data fields hold the head value and are don't-care for checking.
- The queue is strict FIFO. No coalescing of updates to the same index.
- Full and enq with no deq: drop the incoming packet, leave contents unchanged, and increment upd_drop_cnt. The counter saturates at all-ones.
- Full with enq and deq in the same cycle: accept the packet, no drop.
- Empty with enq: the entry is not bypassed. It becomes eligible the next cycle.
- Pointers are log2(DEPTH)+1 bits wide; the extra bit is the wrap bit. full = indices equal and wrap bits differ. empty = pointers equal.
- No flush input. Updates come from resolved branches and stay valid across redirects.

## Timing
- Reset, on the clock edge with reset high: pointers = 0, upd_pending = 0, upd_drop_cnt = 0, all upd_* enables = 0. Entry storage is not reset; its data outputs are don't-care while empty.
- Minimum latency: enq at cycle N → upd_* write at cycle N+1 if bpu_port_busy = 0 at N+1.
- Sustained throughput: 1 packet/cycle while bpu_port_busy = 0.
- upd_pending reflects the registered occupancy: it is high the cycle after the first enq.
- Reset asserted mid-operation: all queued packets are discarded. No upd_* enable is asserted during or in the cycle after reset.

## Structure
- Shared package holds `bpu_upd_entry_t`, a packed struct with all 11 fields. BTB widths are constants (129, 9). Index width comes from `BHTBTB_INDEX_WIDTH`.
- One sub-module, `bpu_upd_fifo`: parameterised DEPTH × `bpu_upd_entry_t` synchronous FIFO with push/pop/full/empty.
- The top level contains only the enq/deq logic, the output gating and the drop counter.

## Test plan
- Single BHT update: enq index 0x12, sel 1, inc, with busy = 0 → at N+1, upd_bht_write_enable = 1 with index 0x12, sel 1, inc = 1. upd_pending goes 0→1→0.
- Busy stall: enq 3 BTB packets (indices 5, 6, 7) while busy = 1 for 6 cycles → no upd_btb_we during the stall. On release, 5, 6, 7 appear in order on consecutive cycles.
- Overflow: DEPTH = 4, busy = 1, enq 6 packets → first 4 are retained, upd_drop_cnt = 2. Drain yields packets 1–4.
- Full with simultaneous enq and deq: queue full, busy drops in the same cycle as a 5th enq → no drop, upd_drop_cnt unchanged, 5 packets drain in order.
- Wrap-around: 10 back-to-back packets with busy toggling every cycle → all 10 emitted in order with no drops. Pointers wrap correctly.
- Reset mid-queue: 3 entries pending, assert reset for 1 cycle → upd_pending = 0, no upd_* enable afterwards until a new enq.

Source files
------------

// File: rtl/bpu_update_queue_pkg.sv
// bpu_update_queue_pkg
//   Shared types and widths for the branch-predictor update queue.
//   bpu_upd_entry_t holds one complete BHT/BTB update packet (11 fields),
//   with the enables kept exactly as the branch unit produced them.
package bpu_update_queue_pkg;

    localparam int unsigned BHTBTB_INDEX_WIDTH = 8;
    localparam int unsigned BTB_DATA_WIDTH     = 129;
    localparam int unsigned BTB_INDEX_WIDTH    = 9;

    typedef struct packed {
        logic                          bht_we;
        logic [BHTBTB_INDEX_WIDTH-1:0] bht_index;
        logic [1:0]                    bht_sel;
        logic                          bht_inc;
        logic                          bht_dec;
        logic                          bht_valid;
        logic                          btb_ce;
        logic                          btb_we;
        logic [BTB_DATA_WIDTH-1:0]     btb_wmask;
        logic [BTB_INDEX_WIDTH-1:0]    btb_index;
        logic [BTB_DATA_WIDTH-1:0]     btb_din;
    } bpu_upd_entry_t;

endpackage

// File: rtl/bpu_update_queue_fifo.sv
// bpu_upd_fifo
//   DEPTH-entry synchronous FIFO of bpu_upd_entry_t.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset (pointers only)
//     push_i         write wdata_i at the tail (caller guarantees space,
//                    or a simultaneous pop when full)
//     pop_i          advance the head (caller guarantees non-empty)
//     rdata_o        head entry, combinational from storage
//     full_o/empty_o occupancy flags
module bpu_upd_fifo
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  bpu_upd_entry_t wdata_i,
    output bpu_upd_entry_t rdata_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    bpu_upd_entry_t   mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + PTR_W'(push_i);
        rptr_d = rptr_q + PTR_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/bpu_update_queue.sv
// bpu_update_queue
//   Buffers branch-predictor update packets from integer writeback and
//   drains them in order into the shared BHT/BTB write port whenever the
//   frontend lookup does not own it.
//   Ports:
//     clock, reset               core clock, synchronous active-high reset
//     intwb_bjusb_*              incoming update packet (BHT + BTB fields)
//     bpu_port_busy              frontend owns the BHT/BTB port this cycle
//     upd_*                      BHT/BTB write port, enables gated by dequeue
//     upd_pending                queue non-empty (registered occupancy)
//     upd_drop_cnt               saturating count of packets dropped when full
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          intwb_bjusb_bht_write_enable,
    input  logic [BHTBTB_INDEX_WIDTH-1:0] intwb_bjusb_bht_write_index,
    input  logic [1:0]                    intwb_bjusb_bht_write_counter_select,
    input  logic                          intwb_bjusb_bht_write_inc,
    input  logic                          intwb_bjusb_bht_write_dec,
    input  logic                          intwb_bjusb_bht_valid_in,
    input  logic                          intwb_bjusb_btb_ce,
    input  logic                          intwb_bjusb_btb_we,
    input  logic [BTB_DATA_WIDTH-1:0]     intwb_bjusb_btb_wmask,
    input  logic [BTB_INDEX_WIDTH-1:0]    intwb_bjusb_btb_write_index,
    input  logic [BTB_DATA_WIDTH-1:0]     intwb_bjusb_btb_din,
    input  logic                          bpu_port_busy,
    output logic                          upd_bht_write_enable,
    output logic [BHTBTB_INDEX_WIDTH-1:0] upd_bht_write_index,
    output logic [1:0]                    upd_bht_write_counter_select,
    output logic                          upd_bht_write_inc,
    output logic                          upd_bht_write_dec,
    output logic                          upd_bht_valid_in,
    output logic                          upd_btb_ce,
    output logic                          upd_btb_we,
    output logic [BTB_DATA_WIDTH-1:0]     upd_btb_wmask,
    output logic [BTB_INDEX_WIDTH-1:0]    upd_btb_write_index,
    output logic [BTB_DATA_WIDTH-1:0]     upd_btb_din,
    output logic                          upd_pending,
    output logic [DROP_CNT_W-1:0]         upd_drop_cnt
);

    bpu_upd_entry_t        in_pkt;
    bpu_upd_entry_t        head;
    logic                  full, empty;
    logic                  enq, deq, push, drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        in_pkt.bht_we    = intwb_bjusb_bht_write_enable;
        in_pkt.bht_index = intwb_bjusb_bht_write_index;
        in_pkt.bht_sel   = intwb_bjusb_bht_write_counter_select;
        in_pkt.bht_inc   = intwb_bjusb_bht_write_inc;
        in_pkt.bht_dec   = intwb_bjusb_bht_write_dec;
        in_pkt.bht_valid = intwb_bjusb_bht_valid_in;
        in_pkt.btb_ce    = intwb_bjusb_btb_ce;
        in_pkt.btb_we    = intwb_bjusb_btb_we;
        in_pkt.btb_wmask = intwb_bjusb_btb_wmask;
        in_pkt.btb_index = intwb_bjusb_btb_write_index;
        in_pkt.btb_din   = intwb_bjusb_btb_din;
    end

    // Dequeue is also blocked while reset is high so no write leaks out
    // of a queue that is being discarded.
    always_comb begin
        enq  = intwb_bjusb_bht_write_enable | (intwb_bjusb_btb_ce & intwb_bjusb_btb_we);
        deq  = !empty && !bpu_port_busy && !reset;
        push = enq && (!full || deq);
        drop = enq && full && !deq;
    end

    bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (deq),
        .wdata_i (in_pkt),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        upd_bht_write_enable         = head.bht_we & deq;
        upd_bht_write_index          = head.bht_index;
        upd_bht_write_counter_select = head.bht_sel;
        upd_bht_write_inc            = head.bht_inc;
        upd_bht_write_dec            = head.bht_dec;
        upd_bht_valid_in             = head.bht_valid;
        upd_btb_ce                   = head.btb_ce & deq;
        upd_btb_we                   = head.btb_we & deq;
        upd_btb_wmask                = head.btb_wmask;
        upd_btb_write_index          = head.btb_index;
        upd_btb_din                  = head.btb_din;
    end

    assign upd_pending  = !empty;
    assign upd_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// tb_bpu_update_queue
//   Scoreboard bench: the monitor logs each issued packet into an expected
//   queue at the clock edge it is accepted and pops/compares whenever the
//   DUT asserts a write enable; directed sequences check order, occupancy
//   and drop counts against hand-computed lists.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           busy;
    bpu_upd_entry_t pin;
    bpu_upd_entry_t pout;
    logic           upd_pending;
    logic [15:0]    upd_drop_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bpu_upd_entry_t mq[$];
    logic [15:0]    mdrop = '0;
    int             log_id[$];
    int             log_cyc[$];

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    bpu_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
        .clock                                (clock),
        .reset                                (reset),
        .intwb_bjusb_bht_write_enable         (pin.bht_we),
        .intwb_bjusb_bht_write_index          (pin.bht_index),
        .intwb_bjusb_bht_write_counter_select (pin.bht_sel),
        .intwb_bjusb_bht_write_inc            (pin.bht_inc),
        .intwb_bjusb_bht_write_dec            (pin.bht_dec),
        .intwb_bjusb_bht_valid_in             (pin.bht_valid),
        .intwb_bjusb_btb_ce                   (pin.btb_ce),
        .intwb_bjusb_btb_we                   (pin.btb_we),
        .intwb_bjusb_btb_wmask                (pin.btb_wmask),
        .intwb_bjusb_btb_write_index          (pin.btb_index),
        .intwb_bjusb_btb_din                  (pin.btb_din),
        .bpu_port_busy                        (busy),
        .upd_bht_write_enable                 (pout.bht_we),
        .upd_bht_write_index                  (pout.bht_index),
        .upd_bht_write_counter_select         (pout.bht_sel),
        .upd_bht_write_inc                    (pout.bht_inc),
        .upd_bht_write_dec                    (pout.bht_dec),
        .upd_bht_valid_in                     (pout.bht_valid),
        .upd_btb_ce                           (pout.btb_ce),
        .upd_btb_we                           (pout.btb_we),
        .upd_btb_wmask                        (pout.btb_wmask),
        .upd_btb_write_index                  (pout.btb_index),
        .upd_btb_din                          (pout.btb_din),
        .upd_pending                          (upd_pending),
        .upd_drop_cnt                         (upd_drop_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clock) begin
        logic           exp_en, dut_en, enq;
        bpu_upd_entry_t e;
        exp_en = !reset && (mq.size() > 0) && !busy;
        dut_en = pout.bht_we | pout.btb_ce | pout.btb_we;
        chk("write_enable", 32'(dut_en), 32'(exp_en));
        chk("pending", 32'(upd_pending), 32'(mq.size() > 0));
        chk("drop_cnt", 32'(upd_drop_cnt), 32'(mdrop));
        if (exp_en) begin
            e = mq.pop_front();
            if (dut_en) begin
                checks++;
                if (pout !== e) begin
                    errors++;
                    $display("FAIL packet: got %h expected %h", pout, e);
                end
            end
        end
        if (dut_en) begin
            log_id.push_back(int'(pout.btb_index));
            log_cyc.push_back(cycle);
        end
        enq = pin.bht_we | (pin.btb_ce & pin.btb_we);
        if (reset) begin
            mq.delete();
            mdrop = '0;
        end else if (enq) begin
            if (mq.size() < DEPTH) mq.push_back(pin);
            else if (mdrop != '1) mdrop = mdrop + 16'd1;
        end
    end

    function automatic bpu_upd_entry_t mk_bht(input int unsigned idx, input int unsigned sel, input bit inc);
        bpu_upd_entry_t p = '0;
        p.bht_we    = 1'b1;
        p.bht_index = BHTBTB_INDEX_WIDTH'(idx);
        p.bht_sel   = 2'(sel);
        p.bht_inc   = inc;
        p.bht_dec   = !inc;
        p.bht_valid = 1'b1;
        p.btb_index = 9'(idx);
        return p;
    endfunction

    function automatic bpu_upd_entry_t mk_btb(input int unsigned idx);
        bpu_upd_entry_t p = '0;
        p.btb_ce    = 1'b1;
        p.btb_we    = 1'b1;
        p.btb_wmask = '1;
        p.btb_index = 9'(idx);
        p.btb_din   = {97'h1_2345_6789_ABCD_EF01_2345_6789, 32'hC0DE_0000 | 32'(idx)};
        return p;
    endfunction

    task automatic step(input bpu_upd_entry_t p, input logic b);
        @(posedge clock);
        #1;
        pin  = p;
        busy = b;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_cyc.delete();
    endtask

    task automatic check_log(input string nm, input int exp[$], input bit consec);
        chk({nm, "_count"}, 32'(log_id.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_id.size(); i++) begin
            chk({nm, "_order"}, 32'(log_id[i]), 32'(exp[i]));
            if (consec && i > 0) chk({nm, "_gap"}, 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
        end
    endtask

    initial begin
        int exp[$];
        pin   = '0;
        busy  = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_pending", 32'(upd_pending), 32'd0);
        chk("rst_drop", 32'(upd_drop_cnt), 32'd0);
        chk("rst_enables", 32'({pout.bht_we, pout.btb_ce, pout.btb_we}), 32'd0);

        // Single BHT update, one-cycle latency
        clear_log();
        step(mk_bht(8'h12, 1, 1'b1), 1'b0);
        @(negedge clock);
        chk("t1_pending_n", 32'(upd_pending), 32'd0);
        step('0, 1'b0);
        @(negedge clock);
        chk("t1_pending_n1", 32'(upd_pending), 32'd1);
        chk("t1_bht_we", 32'(pout.bht_we), 32'd1);
        chk("t1_index", 32'(pout.bht_index), 32'h12);
        chk("t1_sel", 32'(pout.bht_sel), 32'd1);
        chk("t1_inc", 32'(pout.bht_inc), 32'd1);
        step('0, 1'b0);
        @(negedge clock);
        chk("t1_pending_n2", 32'(upd_pending), 32'd0);
        step('0, 1'b0);
        exp = '{32'h12};
        check_log("t1", exp, 1'b0);

        // Busy stall for 6 cycles, then back-to-back drain
        clear_log();
        step(mk_btb(5), 1'b1);
        step(mk_btb(6), 1'b1);
        step(mk_btb(7), 1'b1);
        repeat (3) step('0, 1'b1);
        chk("t2_stall_log", 32'(log_id.size()), 32'd0);
        repeat (5) step('0, 1'b0);
        exp = '{5, 6, 7};
        check_log("t2", exp, 1'b1);

        // Overflow: 6 packets into 4 entries while busy
        clear_log();
        for (int i = 1; i <= 6; i++) step(mk_btb(i), 1'b1);
        step('0, 1'b1);
        @(negedge clock);
        chk("t3_drop", 32'(upd_drop_cnt), 32'd2);
        chk("t3_pending", 32'(upd_pending), 32'd1);
        repeat (6) step('0, 1'b0);
        exp = '{1, 2, 3, 4};
        check_log("t3", exp, 1'b1);

        // Full queue, 5th packet arrives as busy drops: accepted
        clear_log();
        for (int i = 11; i <= 14; i++) step(mk_btb(i), 1'b1);
        step(mk_btb(15), 1'b0);
        repeat (6) step('0, 1'b0);
        exp = '{11, 12, 13, 14, 15};
        check_log("t4", exp, 1'b1);
        @(negedge clock);
        chk("t4_drop", 32'(upd_drop_cnt), 32'd2);

        // Wrap-around: 10 packets, busy toggling each cycle
        clear_log();
        for (int i = 0; i < 10; i++) begin
            step(mk_btb(20 + i), 1'b1);
            step('0, 1'b0);
        end
        repeat (3) step('0, 1'b0);
        exp = '{20, 21, 22, 23, 24, 25, 26, 27, 28, 29};
        check_log("t5", exp, 1'b0);
        @(negedge clock);
        chk("t5_drop", 32'(upd_drop_cnt), 32'd2);

        // Reset with 3 entries pending
        clear_log();
        step(mk_btb(30), 1'b1);
        step(mk_btb(31), 1'b1);
        step(mk_btb(32), 1'b1);
        @(posedge clock);
        #1;
        pin   = '0;
        busy  = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) step('0, 1'b0);
        @(negedge clock);
        chk("t6_pending", 32'(upd_pending), 32'd0);
        chk("t6_drop", 32'(upd_drop_cnt), 32'd0);
        chk("t6_no_writes", 32'(log_id.size()), 32'd0);
        step(mk_btb(40), 1'b0);
        repeat (3) step('0, 1'b0);
        exp = '{40};
        check_log("t6", exp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
